// File: rtl/serial_frame_controller.sv
// serial_frame_controller
// Receive-side frame sequencer for a single-sample-per-bit serial line.
// The FSM finds the start bit, shifts DATA_WIDTH bits in LSB first and checks
// the stop bit. Good bytes are XOR-descrambled into a one-entry valid/ready
// output buffer.
// Optional build macro PARITY_CHECK_EN inserts an even-parity bit after the data.
module serial_frame_controller #(
  parameter int                    DATA_WIDTH     = 8,
  parameter logic [DATA_WIDTH-1:0] DESCRAMBLE_KEY = {DATA_WIDTH{1'b0}},
  parameter int                    COUNT_WIDTH    = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   serialIn,
  input  logic                   enable,
  input  logic                   byteReady,
  output logic [DATA_WIDTH-1:0]  byteOut,
  output logic                   byteValid,
  output logic                   frameError,
  output logic                   overrun,
  output logic                   parityError,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] frameCount
);

  localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t                state, nextState;
  logic [DATA_WIDTH-1:0] shiftReg;
  logic [CW-1:0]         bitCount;
  logic                  parBad;
  logic                  lastBit;
  logic                  stopEdge;
  logic                  goodFrame;
  logic                  load;

  assign lastBit   = (bitCount == CW'(DATA_WIDTH - 1));
  assign stopEdge  = (state == STOP);
  assign goodFrame = stopEdge && serialIn && !parBad;
  // Accept when the buffer is empty or is being drained on this same edge.
  assign load      = goodFrame && (!byteValid || byteReady);
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state logic; a 0 on the stop edge only goes back to IDLE, so it
  // can never be mistaken for a start bit.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (enable && !serialIn) nextState = DATA;
      DATA:    if (lastBit) begin
`ifdef PARITY_CHECK_EN
                 nextState = PARITY;
`else
                 nextState = STOP;
`endif
               end
      PARITY:  nextState = STOP;
      STOP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

`ifdef PARITY_CHECK_EN
  // Even parity: XOR of the data bits and the parity bit must be 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                parBad <= 1'b0;
    else if (state == PARITY) parBad <= (^shiftReg) ^ serialIn;
  end
`else
  assign parBad = 1'b0;
`endif

  // Shift register and bit counter; bits enter at the MSB so the first data
  // bit ends up in bit 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shiftReg <= '0;
      bitCount <= '0;
    end else if (state == IDLE) begin
      bitCount <= '0;
    end else if (state == DATA) begin
      shiftReg <= {serialIn, shiftReg[DATA_WIDTH-1:1]};
      bitCount <= bitCount + 1'b1;
    end
  end

  // Output buffer, good-frame counter and one-cycle error pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byteOut     <= '0;
      byteValid   <= 1'b0;
      frameCount  <= '0;
      frameError  <= 1'b0;
      overrun     <= 1'b0;
      parityError <= 1'b0;
    end else begin
      frameError  <= stopEdge && !serialIn;
      parityError <= stopEdge && parBad;
      overrun     <= goodFrame && byteValid && !byteReady;
      if (load) begin
        byteOut    <= shiftReg ^ DESCRAMBLE_KEY;
        byteValid  <= 1'b1;
        frameCount <= frameCount + 1'b1;
      end else if (byteReady) begin
        byteValid  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/serial_frame_controller.md
Name: serial_frame_controller

Overview:
Sequences the receive path of the serial link: detects a start bit, counts data bits into an internal shift register, checks the stop bit and descrambles the byte. It then hands the byte to the downstream consumer over a valid/ready handshake.
It replaces free-running bit counting with a frame-aware FSM. It sits between the serial line input and the parallel byte consumer.

Parameters:
DATA_WIDTH, 8, data bits per frame (2..16)
DESCRAMBLE_KEY, {DATA_WIDTH{1'b0}}, XOR mask applied to the assembled byte before it is buffered
COUNT_WIDTH, 16, width of the good-frame counter

Ports:
clock  input  1  rising-edge clock; one serial bit is sampled per edge
reset  input  1  asynchronous, active-high reset
serialIn  input  1  serial line; idles high
enable  input  1  1 = start bits accepted; gates only frame start
byteReady  input  1  consumer ready
byteOut  output  DATA_WIDTH  descrambled received byte
byteValid  output  1  byteOut holds an unconsumed byte
frameError  output  1  1-cycle pulse: stop bit sampled 0
overrun  output  1  1-cycle pulse: completed byte dropped because buffer full
parityError  output  1  1-cycle pulse: parity mismatch (tied 0 without PARITY_CHECK_EN)
busy  output  1  FSM not in IDLE
frameCount  output  COUNT_WIDTH  count of frames accepted into the buffer; wraps to 0

Behaviour:
- Reset (async, immediate):
  - FSM to IDLE; shift register, bit counter and byteOut cleared.
  - byteValid, frameError, overrun, parityError, busy and frameCount all 0.
- Frame format, LSB first: start bit (0), DATA_WIDTH data bits, [parity bit], stop bit (1).
- Each bit is sampled on exactly one edge. There is no oversampling.
- IDLE:
  - Edge with enable=1 and serialIn=0 -> DATA, bitCount=0.
  - serialIn=1 or enable=0 -> stay in IDLE.
- DATA:
  - Each edge shifts serialIn in at the MSB end and shifts toward bit 0, so the first data bit ends in bit 0.
  - bitCount increments each edge.
  - On the edge that samples bit DATA_WIDTH-1 -> PARITY if enabled, else STOP.
- STOP: the edge samples serialIn, then the FSM returns to IDLE.
  - Start detection resumes on the next edge, so back-to-back frames with no idle bits are supported.
- On a stop bit of 1 (good frame): candidate byte = shiftReg XOR DESCRAMBLE_KEY.
  - Buffer empty (byteValid=0), or byteValid&&byteReady on the same edge: byteOut <= candidate, byteValid <= 1, frameCount++.
  - Otherwise: old byte kept, candidate dropped, overrun pulses 1, frameCount unchanged.
- On a stop bit of 0: frameError pulses 1.
  - Byte discarded; byteValid and byteOut unchanged.
  - The 0 is not treated as a new start bit.
- Handshake:
  - byteValid stays high until an edge with byteReady=1, which clears it (unless reloaded on that same edge).
  - byteOut is stable while byteValid=1.
- Latency: start bit sampled at edge 0, data at edges 1..DATA_WIDTH, stop at edge DATA_WIDTH+1 (+1 with parity).
  - byteValid is high immediately after the stop edge.
- enable dropping mid-frame does not abort the frame.
- busy = (state != IDLE).
- frameCount wraps from 2^COUNT_WIDTH-1 to 0.
- Error pulses are registered and last exactly one cycle.

Optional Feature:
PARITY_CHECK_EN.
- Defined:
  - PARITY state is inserted after DATA. It samples one even-parity bit, so XOR of data bits and parity bit = 0.
  - On mismatch: parityError pulses 1 at the stop edge, the byte is discarded, and the STOP state is still traversed.
  - If parity and stop are both bad, both pulses fire.
- Undefined: no PARITY state, frame is DATA_WIDTH+2 bits, parityError is constant 0.

Test Plan:
- Defaults: after reset, line idle 1, send 0, then 1,0,1,0,0,1,0,1, then 1.
  - Required: byteOut=0xA5 and byteValid=1 right after edge 9; frameCount=1; busy low after edge 9.
- DESCRAMBLE_KEY=0xFF, same frame.
  - Required: byteOut=0x5A.
- byteReady=0, two back-to-back frames 0x3C then 0xC3.
  - Required: byteOut stays 0x3C; overrun pulses 1 cycle at the second stop edge; frameCount=1.
  - Repeat with byteReady=1 at the second stop edge: byteOut=0xC3, byteValid stays 1, frameCount=2.
- Frame 0x81 with stop bit 0, line then held 1.
  - Required: frameError pulses once; byteValid stays 0; FSM in IDLE and no phantom frame starts.
- Assert reset at edge 4 of a frame, release, send 0x55.
  - Required: all outputs 0 during reset; byteOut=0x55 after the clean frame; frameCount=1.
- PARITY_CHECK_EN, frame 0x07 with parity bit 0 (wrong, correct is 1).
  - Required: parityError pulses at the stop edge; byteValid=0.
  - With parity bit 1: byteOut=0x07, byteValid=1.
